// File: rtl/system_btn_seq_pkg.sv
// Shared types and constants for the button sequencer: FSM states,
// register map, STATUS bit layout and CMD field positions.
package system_btn_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_GAP    = 2'd3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_FULL      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_DONE      = 4;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int CMD_IDX_LSB = 16;
    localparam int GAP_RESET   = 16;

endpackage

// File: rtl/system_btn_seq_fifo.sv
// Small synchronous command FIFO. A pop in the same cycle frees a slot,
// so a push into a full FIFO is still accepted when it coincides with a pop.
module system_btn_seq_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_wdata;
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/system_button_sequencer.sv
// Avalon-MM slave that plays back queued {button, hold} commands as timed
// one-hot presses, each followed by a programmable gap.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | no press active; pops the next command when EN is set
//   ST_PRESS | one button driven high, counting down the hold time
//   ST_GAP   | all buttons low, counting down the inter-press gap
module system_button_sequencer
    import system_btn_seq_pkg::*;
#(
    parameter int NUM_BTN    = 4,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic [NUM_BTN-1:0] btn_out,
    output logic               irq
);

    localparam int IDX_W = $clog2(NUM_BTN);
    localparam int FW    = CNT_W + IDX_W;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_BTN-1:0] r_btn;
    logic               r_en;
    logic               r_irq_en;
    logic [CNT_W-1:0]   r_gap;
    logic               r_ovf;
    logic               r_done;
    logic               r_irq;

    logic               w_wr;
    logic               w_cmd_wr;
    logic               w_stat_wr;
    logic               w_ctrl_wr;
    logic               w_gap_wr;
    logic [FW-1:0]      w_fifo_wdata;
    logic [FW-1:0]      w_fifo_rdata;
    logic [CNT_W-1:0]   w_head_hold;
    logic [IDX_W-1:0]   w_head_idx;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic               w_pop;
    logic               w_to_idle;
    logic               w_done_set;
    logic               w_ovf_set;
    logic               w_ovf_nxt;
    logic               w_done_nxt;
    logic               w_irq_en_nxt;
    logic [31:0]        w_status;
    logic               w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_cmd_wr  = w_wr & (address == ADDR_CMD);
    assign w_stat_wr = w_wr & (address == ADDR_STATUS);
    assign w_ctrl_wr = w_wr & (address == ADDR_CTRL);
    assign w_gap_wr  = w_wr & (address == ADDR_GAP);

    // Upper CMD bits beyond the index field are intentionally ignored.
    assign w_unused = ^writedata;

    assign w_fifo_wdata = {writedata[CMD_IDX_LSB +: IDX_W], writedata[CNT_W-1:0]};
    assign w_head_hold  = w_fifo_rdata[CNT_W-1:0];
    assign w_head_idx   = w_fifo_rdata[FW-1:CNT_W];

    assign w_pop = (r_state == ST_IDLE) & r_en & ~w_empty;

    system_btn_seq_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_cmd_wr),
        .i_pop   (w_pop),
        .i_wdata (w_fifo_wdata),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_to_idle = ((r_state == ST_PRESS) & (r_cnt == CNT_W'(1)) & (r_gap == '0))
                     | ((r_state == ST_GAP)   & (r_cnt == CNT_W'(1)));

    assign w_done_set = w_to_idle & w_empty;
    assign w_ovf_set  = w_cmd_wr & w_full & ~w_pop;

    // W1C clear first, then set, so a same-cycle set wins.
    assign w_ovf_nxt    = (r_ovf  & ~(w_stat_wr & writedata[STAT_OVF]))  | w_ovf_set;
    assign w_done_nxt   = (r_done & ~(w_stat_wr & writedata[STAT_DONE])) | w_done_set;
    assign w_irq_en_nxt = w_ctrl_wr ? writedata[CTRL_IRQ_EN] : r_irq_en;

    // Control registers, sticky flags and the registered interrupt line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_gap    <= CNT_W'(GAP_RESET);
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr)
                r_en <= writedata[CTRL_EN];
            if (w_gap_wr)
                r_gap <= writedata[CNT_W-1:0];
            r_irq_en <= w_irq_en_nxt;
            r_ovf    <= w_ovf_nxt;
            r_done   <= w_done_nxt;
            r_irq    <= w_irq_en_nxt & (w_done_nxt | w_ovf_nxt);
        end
    end

    // Press/gap sequencer; btn_out is registered so it is glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_btn   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_cnt   <= (w_head_hold == '0) ? CNT_W'(1) : w_head_hold;
                        r_btn   <= NUM_BTN'(1) << w_head_idx;
                        r_state <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_btn <= '0;
                        if (r_gap == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt   <= r_gap;
                            r_state <= ST_GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == CNT_W'(1))
                        r_state <= ST_IDLE;
                    else
                        r_cnt <= r_cnt - CNT_W'(1);
                end
                default: begin
                    r_btn   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // STATUS word assembly.
    always_comb begin
        w_status                            = '0;
        w_status[STAT_BUSY]                 = (r_state != ST_IDLE);
        w_status[STAT_EMPTY]                = w_empty;
        w_status[STAT_FULL]                 = w_full;
        w_status[STAT_OVF]                  = r_ovf;
        w_status[STAT_DONE]                 = r_done;
        w_status[STAT_COUNT_LSB +: CW]      = w_count;
    end

    // Combinational read mux; CMD is write-only.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CMD:    readdata = '0;
            ADDR_STATUS: readdata = w_status;
            ADDR_CTRL:   readdata = {30'd0, r_irq_en, r_en};
            ADDR_GAP:    readdata = 32'(r_gap);
            default:     readdata = '0;
        endcase
    end

    assign btn_out = r_btn;
    assign irq     = r_irq;

endmodule

// File: tb/tb_system_button_sequencer.sv
// Directed bench for system_button_sequencer. Inputs change on the falling
// edge; outputs are sampled in the low phase, away from the rising edge.
module tb_system_button_sequencer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  btn_out;
    logic        irq;

    int          n_checks;
    int          n_errors;
    logic [31:0] rd;
    logic [3:0]  exp_seq [0:12];
    int          n_high;

    system_button_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .btn_out    (btn_out),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;

        // ---- reset state
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(2'd0, rd); check("rst_cmd",    rd, 32'h0);
        bus_read(2'd1, rd); check("rst_status", rd, 32'h002);
        bus_read(2'd2, rd); check("rst_ctrl",   rd, 32'h0);
        bus_read(2'd3, rd); check("rst_gap",    rd, 32'd16);
        check("rst_btn", {28'd0, btn_out}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);

        // ---- single press: idx1 hold5, gap2
        bus_write(2'd2, 32'h1);
        bus_write(2'd3, 32'd2);
        bus_write(2'd0, (32'd1 << 16) | 32'd5);
        check("p1_k0", {28'd0, btn_out}, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("p1_k%0d", k), {28'd0, btn_out},
                  (k >= 1 && k <= 5) ? 32'h2 : 32'h0);
        end
        bus_read(2'd1, rd); check("p1_done_status", rd, 32'h012);
        bus_write(2'd1, 32'h10);
        bus_read(2'd1, rd); check("p1_done_clr", rd, 32'h002);

        // ---- three queued commands, gap 0, including hold=0
        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'd0);
        bus_write(2'd0, (32'd0 << 16) | 32'd3);
        bus_write(2'd0, (32'd3 << 16) | 32'd0);
        bus_write(2'd0, (32'd2 << 16) | 32'd4);
        bus_read(2'd1, rd); check("q3_status", rd, 32'h300);
        exp_seq[0]  = 4'b0000;
        exp_seq[1]  = 4'b0001; exp_seq[2]  = 4'b0001; exp_seq[3]  = 4'b0001;
        exp_seq[4]  = 4'b0000;
        exp_seq[5]  = 4'b1000;
        exp_seq[6]  = 4'b0000;
        exp_seq[7]  = 4'b0100; exp_seq[8]  = 4'b0100;
        exp_seq[9]  = 4'b0100; exp_seq[10] = 4'b0100;
        exp_seq[11] = 4'b0000; exp_seq[12] = 4'b0000;
        bus_write(2'd2, 32'h1);
        check("q3_k0", {28'd0, btn_out}, {28'd0, exp_seq[0]});
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("q3_k%0d", k), {28'd0, btn_out}, {28'd0, exp_seq[k]});
        end
        bus_read(2'd1, rd); check("q3_end_status", rd, 32'h012);
        bus_write(2'd1, 32'h10);

        // ---- overflow with EN=0, then IRQ handling
        bus_write(2'd2, 32'h0);
        bus_write(2'd0, (32'd2 << 16) | 32'd4);
        bus_write(2'd0, (32'd3 << 16) | 32'd4);
        bus_write(2'd0, (32'd0 << 16) | 32'd4);
        bus_write(2'd0, (32'd1 << 16) | 32'd4);
        bus_write(2'd0, (32'd1 << 16) | 32'd4);
        bus_read(2'd1, rd); check("ovf_status", rd, 32'h40C);
        check("ovf_irq_masked", {31'd0, irq}, 32'h0);
        bus_write(2'd2, 32'h2);
        check("ovf_irq_on", {31'd0, irq}, 32'h1);
        bus_write(2'd1, 32'h8);
        check("ovf_irq_cleared", {31'd0, irq}, 32'h0);
        bus_read(2'd1, rd); check("ovf_status_clr", rd, 32'h404);

        // ---- clear EN during second press; rest stays queued
        bus_write(2'd3, 32'd2);
        bus_write(2'd2, 32'h3);
        n_high = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (btn_out != 4'b0000) n_high++;
            if (k == 4) check("en_first_idx",  {28'd0, btn_out}, 32'h4);
            if (k == 8) check("en_second_idx", {28'd0, btn_out}, 32'h8);
            if (k == 9) begin
                address    = 2'd2;
                writedata  = 32'h2;
                chipselect = 1'b1;
                write_n    = 1'b0;
            end
            if (k == 10) begin
                chipselect = 1'b0;
                write_n    = 1'b1;
            end
        end
        check("en_high_cycles", n_high, 32'd8);
        bus_read(2'd1, rd); check("en_status", rd, 32'h200);
        check("en_irq", {31'd0, irq}, 32'h0);

        // ---- asynchronous reset mid-press
        bus_write(2'd2, 32'h1);
        @(negedge clk);
        @(negedge clk);
        check("ar_press", {28'd0, btn_out}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_btn_async", {28'd0, btn_out}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("ar_btn_after", {28'd0, btn_out}, 32'h0);
        bus_read(2'd1, rd); check("ar_status", rd, 32'h002);
        bus_read(2'd2, rd); check("ar_ctrl",   rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
